// File: rtl/pc_sequencer.sv
// pc_sequencer: per-retired-instruction PC sequencing with a return-address stack.
// Ports:
//   clock_i, reset_n_i         clock, asynchronous active-low reset
//   pc_i                       address of the retiring instruction
//   instr_done_i               one-cycle retire pulse; op_*, zero_flag_i, target_i valid with it
//   stall_i                    downstream not ready; holds back pc_step_o
//   op_*_i, zero_flag_i        decoded control-flow class and ALU zero flag
//   target_i                   branch/call destination
//   pc_step_o, jump_o          one-cycle PC update strobe; load (1) or increment (0)
//   jump_data_o                load value, valid with pc_step_o && jump_o
//   halted_o, stack_fault_o    sticky terminal status
//   depth_o                    return-address stack occupancy
module pc_sequencer #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  instr_done_i,
    input  logic                  stall_i,
    input  logic                  op_jump_i,
    input  logic                  op_beq_i,
    input  logic                  op_call_i,
    input  logic                  op_ret_i,
    input  logic                  op_halt_i,
    input  logic                  zero_flag_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic                  pc_step_o,
    output logic                  jump_o,
    output logic [ADDR_WIDTH-1:0] jump_data_o,
    output logic                  halted_o,
    output logic                  stack_fault_o,
    output logic [2:0]            depth_o
);
    typedef enum logic [2:0] {BOOT, RUN, HOLD, HALT, FAULT} state_e;
    state_e                state_q;
    logic                  pc_step_q, jump_q, halted_q, fault_q, pend_jump_q;
    logic [ADDR_WIDTH-1:0] jump_data_q, pend_data_q;
    logic [2:0]            depth_q;
    // Sized for the largest legal depth so a 3-bit occupancy indexes it directly.
    logic [ADDR_WIDTH-1:0] stack_q [8];
    logic                  retire, full, empty, fault_d, push_d, pop_d, jump_d;
    logic [ADDR_WIDTH-1:0] data_d;
    logic [2:0]            depth_d;

    always_comb begin
        retire  = state_q == RUN && instr_done_i;
        full    = depth_q == 3'(STACK_DEPTH);
        empty   = depth_q == 3'd0;
        // Halt outranks everything; ret outranks call, so a ret decides the fault alone.
        fault_d = !op_halt_i && (op_ret_i ? empty : op_call_i && full);
        pop_d   = !op_halt_i && op_ret_i && !empty;
        push_d  = !op_halt_i && !op_ret_i && op_call_i && !full;
        jump_d  = op_ret_i || op_call_i || op_jump_i || (op_beq_i && zero_flag_i);
        data_d  = op_ret_i ? stack_q[depth_q - 3'd1] : target_i;
        depth_d = push_d ? depth_q + 3'd1 : pop_d ? depth_q - 3'd1 : depth_q;
    end

    // Stack contents need no reset; only occupancy is architecturally visible.
    always_ff @(posedge clock_i) begin
        if (retire && push_d) stack_q[depth_q] <= pc_i + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= BOOT;
            pc_step_q   <= 1'b0;
            jump_q      <= 1'b0;
            jump_data_q <= '0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            depth_q     <= 3'd0;
            pend_jump_q <= 1'b0;
            pend_data_q <= '0;
        end else begin
            pc_step_q <= 1'b0;
            jump_q    <= 1'b0;
            case (state_q)
                BOOT: if (!stall_i) begin
                    pc_step_q   <= 1'b1;
                    jump_q      <= 1'b1;
                    jump_data_q <= '0;
                    state_q     <= RUN;
                end
                RUN: if (instr_done_i) begin
                    if (op_halt_i) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else if (fault_d) begin
                        fault_q <= 1'b1;
                        state_q <= FAULT;
                    end else begin
                        // Stack and depth commit at retire, independent of when the step issues.
                        depth_q     <= depth_d;
                        pend_jump_q <= jump_d;
                        pend_data_q <= data_d;
                        if (stall_i) begin
                            state_q <= HOLD;
                        end else begin
                            pc_step_q <= 1'b1;
                            jump_q    <= jump_d;
                            if (jump_d) jump_data_q <= data_d;
                        end
                    end
                end
                HOLD: if (!stall_i) begin
                    pc_step_q <= 1'b1;
                    jump_q    <= pend_jump_q;
                    if (pend_jump_q) jump_data_q <= pend_data_q;
                    state_q   <= RUN;
                end
                default: ;
            endcase
        end
    end

    assign pc_step_o     = pc_step_q;
    assign jump_o        = jump_q;
    assign jump_data_o   = jump_data_q;
    assign halted_o      = halted_q;
    assign stack_fault_o = fault_q;
    assign depth_o       = depth_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; expected steps queued at retire, popped on pc_step.
module tb_pc_sequencer;
    localparam logic [4:0] N = 5'b00000, B = 5'b00001, J = 5'b00010,
                           C = 5'b00100, R = 5'b01000, H = 5'b10000;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] pc = '0, target = '0;
    logic       instr_done = 0, stall = 0, op_jump = 0, op_beq = 0, op_call = 0, op_ret = 0, op_halt = 0, zf = 0;
    logic       pc_step, jump, halted, fault;
    logic [7:0] jump_data;
    logic [2:0] depth;
    logic [8:0] sb [$];
    int         checks = 0, failures = 0;

    pc_sequencer #(.STACK_DEPTH(4), .ADDR_WIDTH(8)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .pc_i(pc), .instr_done_i(instr_done), .stall_i(stall),
        .op_jump_i(op_jump), .op_beq_i(op_beq), .op_call_i(op_call), .op_ret_i(op_ret), .op_halt_i(op_halt),
        .zero_flag_i(zf), .target_i(target), .pc_step_o(pc_step), .jump_o(jump), .jump_data_o(jump_data),
        .halted_o(halted), .stack_fault_o(fault), .depth_o(depth)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed step must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && pc_step) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL step_unexpected: got step jump=%0b data=%h, expected no step", jump, jump_data);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if (jump !== e[8] || (e[8] && jump_data !== e[7:0])) begin
                    failures++;
                    $display("FAIL step_value: got jump=%0b data=%h, expected jump=%0b data=%h", jump, jump_data, e[8], e[7:0]);
                end
            end
        end else if (rst_n) begin
            checks++;
            if (jump !== 1'b0) begin
                failures++;
                $display("FAIL jump_idle: got jump=%0b without step, expected 0", jump);
            end
        end
    end

    task automatic clear_ops();
        instr_done = 0; op_jump = 0; op_beq = 0; op_call = 0; op_ret = 0; op_halt = 0; zf = 0;
    endtask

    // Drives a one-cycle retire starting at a falling edge; returns on the next falling edge.
    task automatic retire(input logic [4:0] ops, input logic z, input logic [7:0] t, input logic [7:0] p);
        {op_halt, op_ret, op_call, op_jump, op_beq} = ops;
        instr_done = 1; zf = z; target = t; pc = p;
        @(negedge clk);
        clear_ops();
    endtask

    task automatic do_reset();
        rst_n = 0; stall = 0;
        clear_ops();
        repeat (2) @(negedge clk);
        sb.delete();
        sb.push_back(9'h100);
        rst_n = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pc_step, jump, jump_data, halted, fault, depth} !== 15'd0) begin
            failures++;
            $display("FAIL reset_state: got step=%0b jump=%0b data=%h halt=%0b fault=%0b depth=%0d, expected all 0",
                     pc_step, jump, jump_data, halted, fault, depth);
        end
        sb.push_back(9'h100);
        rst_n = 1;
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL boot_step: got %0d steps outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_seq_beq();
        sb.push_back(9'h000); retire(N, 0, 8'h40, 8'h01);
        sb.push_back(9'h140); retire(B, 1, 8'h40, 8'h02);
        sb.push_back(9'h000); retire(B, 0, 8'h40, 8'h41);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL seq_beq_steps: got %0d outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back(9'h000); sb.push_back(9'h133); sb.push_back(9'h144);
        retire(N, 0, 8'h00, 8'h05);
        retire(J, 0, 8'h33, 8'h06);
        retire(B, 1, 8'h44, 8'h33);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL back_to_back: got %0d outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_call_ret();
        sb.push_back(9'h180); retire(C, 0, 8'h80, 8'h10);
        sb.push_back(9'h190); retire(C, 0, 8'h90, 8'hFF);
        repeat (2) @(negedge clk);
        checks++;
        if (depth !== 3'd2) begin
            failures++;
            $display("FAIL call_depth: got %0d, expected 2", depth);
        end
        sb.push_back(9'h100); retire(R, 0, 8'h00, 8'h90);
        checks++;
        if (depth !== 3'd1) begin
            failures++;
            $display("FAIL ret_depth1: got %0d, expected 1", depth);
        end
        sb.push_back(9'h111); retire(R, 0, 8'h00, 8'h01);
        repeat (2) @(negedge clk);
        checks++;
        if (depth !== 3'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL ret_final: got depth=%0d outstanding=%0d, expected 0 and 0", depth, sb.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b1, 8'(8'hA0 + i)});
            retire(C, 0, 8'(8'hA0 + i), 8'(i));
        end
        retire(C, 0, 8'hEE, 8'h50);
        checks++;
        if (fault !== 1'b1 || depth !== 3'd4) begin
            failures++;
            $display("FAIL overflow: got fault=%0b depth=%0d, expected 1 and 4", fault, depth);
        end
        retire(N, 0, 8'h00, 8'h51);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || fault !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL overflow_terminal: got outstanding=%0d fault=%0b halted=%0b, expected 0 1 0", sb.size(), fault, halted);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        retire(R, 0, 8'h00, 8'h07);
        checks++;
        if (fault !== 1'b1 || depth !== 3'd0) begin
            failures++;
            $display("FAIL underflow: got fault=%0b depth=%0d, expected 1 and 0", fault, depth);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall_priority();
        do_reset();
        stall = 1;
        sb.push_back(9'h122);
        retire(J | C, 0, 8'h22, 8'h30);
        instr_done = 1; op_call = 1; target = 8'h77;
        @(negedge clk);
        clear_ops();
        @(negedge clk);
        checks++;
        if (depth !== 3'd1 || pc_step !== 1'b0) begin
            failures++;
            $display("FAIL hold_frozen: got depth=%0d step=%0b, expected 1 and 0", depth, pc_step);
        end
        stall = 0;
        @(negedge clk);
        checks++;
        if (pc_step !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: got step=%0b, expected 1", pc_step);
        end
        repeat (2) @(negedge clk);
        retire(H | J, 0, 8'h55, 8'h22);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b0) begin
            failures++;
            $display("FAIL halt: got halted=%0b fault=%0b, expected 1 and 0", halted, fault);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_terminal: got outstanding=%0d halted=%0b, expected 0 and 1", sb.size(), halted);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stall = 1;
        sb.push_back(9'h150);
        retire(C, 0, 8'h50, 8'h20);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({pc_step, jump, jump_data, halted, fault, depth} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset: got step=%0b jump=%0b data=%h halt=%0b fault=%0b depth=%0d, expected all 0",
                     pc_step, jump, jump_data, halted, fault, depth);
        end
        @(negedge clk);
        sb.delete();
        stall = 0;
        sb.push_back(9'h100);
        rst_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || depth !== 3'd0) begin
            failures++;
            $display("FAIL reboot: got outstanding=%0d depth=%0d, expected 0 and 0", sb.size(), depth);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_seq_beq();
        test_back_to_back();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_stall_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block that sequences the 8-bit program counter of the nRisc core. It decides, once per retired instruction, whether the PC steps sequentially, loads a branch/call target, or loads a return address from an internal return-address stack. It halts fetch on a halt instruction or a stack fault. It sits between the decode/execute stage (which reports instruction completion and decoded control-flow class) and the program counter (which consumes a one-cycle step strobe plus `jump`/`jump_data`).

## Interface
- `STACK_DEPTH`, 4: return-address stack entries; legal values are 1..7.
- `ADDR_WIDTH`, 8: PC/target width.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_WIDTH  current PC value, the address of the retiring instruction.
- `instr_done`  in  1  one-cycle pulse: current instruction finished; op_* and target are valid this cycle.
- `stall`  in  1  downstream not ready; while high, no `pc_step` is issued.
- `op_jump`, `op_beq`, `op_call`, `op_ret`, `op_halt`  in  1 each  decoded control-flow class, sampled only with `instr_done`.
- `zero_flag`  in  1  ALU zero flag, sampled with `instr_done`.
- `target`  in  ADDR_WIDTH  branch/call destination, sampled with `instr_done`.
- `pc_step`  out  1  one-cycle strobe: PC updates this cycle.
- `jump`  out  1  with `pc_step`: 1 = load `jump_data`, 0 = increment.
- `jump_data`  out  ADDR_WIDTH  load value; valid when `pc_step && jump`.
- `halted`  out  1  sticky; set by halt.
- `stack_fault`  out  1  sticky; set by push-when-full or pop-when-empty.
- `depth`  out  3  current stack occupancy, 0..STACK_DEPTH.

## Operation
- All outputs are registered. Reset values: `pc_step`=0, `jump`=0, `jump_data`=0, `halted`=0, `stack_fault`=0, `depth`=0. Stack contents are don't-care after reset. State after reset is BOOT.
- States:
  - **BOOT**: on the first edge after `reset_n` rises, if `stall`=0, issue `pc_step`=1, `jump`=1, `jump_data`=0, then go to RUN. If `stall`=1, stay in BOOT.
  - **RUN**: wait for `instr_done`. On `instr_done`, capture the decision (below) into a pending register. If `stall`=0, issue the step next cycle and stay in RUN. If `stall`=1, go to HOLD.
  - **HOLD**: the pending decision is frozen. Issue it on the first cycle with `stall`=0, then return to RUN. `instr_done` is ignored in HOLD.
  - **HALT**: terminal. No `pc_step`. `halted`=1. Exit only by reset.
  - **FAULT**: terminal. No `pc_step`. `stack_fault`=1. Exit only by reset.
- Decision priority when several op bits are high: halt > ret > call > jump > beq > sequential.
  - **halt**: go to HALT; no step issued.
  - **ret**: if `depth`=0, go to FAULT. Otherwise pop; `jump`=1, `jump_data`=popped value; `depth`−1.
  - **call**: if `depth`=STACK_DEPTH, go to FAULT. Otherwise push `pc+1` (mod 2^ADDR_WIDTH, so 0xFF wraps to 0x00); `jump`=1, `jump_data`=`target`; `depth`+1.
  - **jump**: `jump`=1, `jump_data`=`target`.
  - **beq**: `zero_flag`=1 gives `jump`=1, `jump_data`=`target`. `zero_flag`=0 gives `jump`=0.
  - **none**: `jump`=0 (sequential increment).
- Stack push/pop and `depth` update occur on the `instr_done` edge, not at issue, so `depth` reflects the op even while in HOLD.
- When `pc_step`=0, `jump` is driven 0 and `jump_data` holds its last value.

## Timing
- Latency from `instr_done` (with `stall`=0) to `pc_step` is exactly 1 cycle. `pc_step` is high for exactly 1 cycle per retired instruction.
- With `stall`: the step issues on the cycle after `stall` is first sampled low.
- `instr_done` asserted on the same cycle `pc_step` is high is legal and handled normally in RUN.
- Reset asserted mid-HOLD or mid-step: all outputs return to reset values immediately (asynchronously). The pending decision and stack are discarded. The block re-enters BOOT.
- `halted` and `stack_fault` assert on the cycle after the triggering `instr_done`, and remain set.

## Test plan
- **Boot:** release `reset_n` with `stall`=0 → next cycle `pc_step`=1, `jump`=1, `jump_data`=0x00. Then idle, with no further `pc_step`.
- **Sequential and beq:**
  - `instr_done` with no op → next cycle `pc_step`=1, `jump`=0.
  - beq with `zero_flag`=1, `target`=0x40 → `jump`=1, `jump_data`=0x40.
  - Same with `zero_flag`=0 → `jump`=0.
- **Call/ret nesting:**
  - Calls at pc=0x10 (target 0x80) and pc=0xFF (target 0x90) → `depth`=2.
  - Ret → `jump_data`=0x00 (wrap). Second ret → `jump_data`=0x11, `depth`=0.
- **Faults:**
  - 5 calls with STACK_DEPTH=4 → 5th gives no `pc_step`, `stack_fault`=1, `depth` stays 4.
  - Separate run: ret at depth 0 → `stack_fault`=1.
- **Stall and priority:**
  - `instr_done` with `op_jump`+`op_call`, `target`=0x22, while `stall`=1 for 3 cycles → `pc_step` appears 1 cycle after `stall` falls, with `jump_data`=0x22 and `depth`=1.
  - `op_halt`+`op_jump` → `halted`=1 and no `pc_step`.
- **Async reset mid-HOLD:** pull `reset_n` low while in HOLD → outputs zero immediately, `depth`=0. After release, BOOT step to 0x00.
